// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_arbiter
//  Description : Round-robin arbiter/sequencer sharing a small register bank
//                (registered one-cycle read) among NREQ requesters. One
//                command in flight at a time; illegal addresses are answered
//                with an error and never reach the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbank_arbiter #(
    parameter int NREQ     = 2,
    parameter int AW       = 4,
    parameter int DW       = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_err,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rf_wr,
    output logic [AW-1:0]        rf_addr,
    output logic [DW-1:0]        rf_wdata,
    input  logic [DW-1:0]        rf_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RDLAT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic              err_q, err_d;
    logic [AW-1:0]     rf_addr_q, rf_addr_d;
    logic [DW-1:0]     rf_wdata_q, rf_wdata_d;

    logic [NREQ-1:0]   rsp_valid_q;
    logic              rsp_err_q;
    logic [DW-1:0]     rsp_rdata_q;

    // Arbitration results and the selected requester's command fields
    logic              any_valid;
    logic [PW-1:0]     win_idx;
    logic [PW:0]       cand;
    logic              sel_wr;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [NREQ-1:0]   ready_c;

    // Round-robin search upward from ptr+1, wrapping at NREQ
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i + 1);
            if (int'(cand) >= NREQ) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!any_valid && req_valid[cand[PW-1:0]]) begin
                any_valid = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    // Mux out the winning requester's command fields
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Sequencer next-state logic; bank address/data are latched at accept so
    // they are already stable when ISSUE presents them
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cmd_wr_d   = cmd_wr_q;
        err_d      = err_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        ready_c    = '0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    ready_c[win_idx] = 1'b1;
                    ptr_d            = win_idx;
                    gnt_d            = win_idx;
                    cmd_wr_d         = sel_wr;
                    if (int'(sel_addr) < NUM_REGS) begin
                        err_d      = 1'b0;
                        rf_addr_d  = sel_addr;
                        rf_wdata_d = sel_wdata;
                        state_d    = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: state_d = cmd_wr_q ? S_RESP : S_RDLAT;
            S_RDLAT: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(NREQ - 1);
            gnt_q      <= '0;
            cmd_wr_q   <= 1'b0;
            err_q      <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cmd_wr_q   <= cmd_wr_d;
            err_q      <= err_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Registered response: valid only for the cycle spent in RESP; read data is
    // taken from the bank on the RDLAT->RESP edge, zero otherwise
    always_ff @(posedge clk) begin
        if (rst || state_d != S_RESP) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= NREQ'(1) << gnt_d;
            rsp_err_q   <= err_d;
            rsp_rdata_q <= (state_q == S_RDLAT) ? rf_rdata : '0;
        end
    end

    assign req_ready = rst ? '0 : ready_c;
    assign rf_wr     = ~rst & (state_q == S_ISSUE) & cmd_wr_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_regbank_arbiter
//  Description : Self-checking bench for regbank_arbiter with a behavioural
//                4 x 32-bit register bank and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_wr = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_wdata = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic                rsp_err;
    logic [DW-1:0]       rsp_rdata;
    logic                rf_wr;
    logic [AW-1:0]       rf_addr;
    logic [DW-1:0]       rf_wdata;
    logic [DW-1:0]       rf_rdata = '0;

    regbank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural bank: write on wr, registered one-cycle read of addrin
    logic [DW-1:0] bank [4] = '{default: '0};
    always @(posedge clk) begin
        if (rf_wr) bank[rf_addr[1:0]] <= rf_wdata;
        rf_rdata <= bank[rf_addr[1:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    always @(negedge clk) begin
        if (rf_wr) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = rf_addr;
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [NREQ-1:0] vld;
        logic            err;
        logic [DW-1:0]   data;
        int              due;
    } exp_t;
    exp_t sb[$];

    // Monitor: every presented response is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected rsp_valid", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e.vld));
                check("rsp_err",   64'(rsp_err),   64'(e.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                check("rsp latency cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    function automatic int lat_of(input bit wr, input logic [AW-1:0] a);
        if (int'(a) >= 4) return 1;
        return wr ? 2 : 3;
    endfunction

    // Present one command from requester r, wait for accept, queue expectation
    task automatic issue(input int r, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         output int acc);
        exp_t e;
        bit   bad;
        @(negedge clk);
        req_valid[r]            = 1'b1;
        req_wr[r]               = wr;
        req_addr[r*AW +: AW]    = a;
        req_wdata[r*DW +: DW]   = d;
        acc = -1;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (req_ready[r]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept timeout", 64'(0), 64'(1));
            req_valid[r] = 1'b0;
            return;
        end
        check("req_ready onehot", 64'(req_ready), 64'(1) << r);
        bad    = (int'(a) >= 4);
        e.vld  = NREQ'(1) << r;
        e.err  = bad;
        e.data = (wr || bad) ? '0 : exp_rd;
        e.due  = acc + lat_of(wr, a);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'(0));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, " rsp_err"},   64'(rsp_err),   64'(0));
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({tag, " rf_wr"},     64'(rf_wr),     64'(0));
        check({tag, " rf_addr"},   64'(rf_addr),   64'(0));
        check({tag, " rf_wdata"},  64'(rf_wdata),  64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, wc0, n, grants;
        int order [4] = '{0, 1, 0, 1};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Requester 0 writes 0xDEADBEEF to address 2
        wc0 = wr_cnt;
        issue(0, 1'b1, 4'd2, 32'hDEADBEEF, '0, acc);
        drain();
        check("write rf_wr pulses", 64'(wr_cnt - wc0), 64'(1));
        check("write rf_addr", 64'(last_wr_addr), 64'(2));

        // Requester 1 reads it back; no write strobe allowed
        wc0 = wr_cnt;
        issue(1, 1'b0, 4'd2, '0, 32'hDEADBEEF, acc);
        drain();
        check("read rf_wr pulses", 64'(wr_cnt - wc0), 64'(0));

        // Both requesters persistently request writes: grants alternate 0,1,0,1
        @(negedge clk);
        req_wr    = 2'b11;
        req_addr  = {4'd1, 4'd0};
        req_wdata = {32'h22, 32'h11};
        req_valid = 2'b11;
        n = 0;
        for (int t = 0; t < 60 && n < 4; t++) begin
            #1;
            if (req_ready != '0) begin
                exp_t e;
                check("grant order", 64'(req_ready), 64'(1) << order[n]);
                e.vld  = NREQ'(1) << order[n];
                e.err  = 1'b0;
                e.data = '0;
                e.due  = cyc + 2;
                sb.push_back(e);
                n = n + 1;
                if (n == 4) begin
                    @(posedge clk);
                    #1 req_valid = '0;
                end
            end
            if (n < 4) @(negedge clk);
        end
        grants = n;
        req_valid = '0;
        check("grant count", 64'(grants), 64'(4));
        drain();
        issue(0, 1'b0, 4'd0, '0, 32'h11, acc);
        issue(1, 1'b0, 4'd1, '0, 32'h22, acc);
        drain();

        // Illegal address: error response after one cycle, bank untouched
        wc0 = wr_cnt;
        issue(0, 1'b0, 4'd7, '0, '0, acc);
        drain();
        check("illegal rf_wr pulses", 64'(wr_cnt - wc0), 64'(0));
        check("bank[0]", 64'(bank[0]), 64'(32'h11));
        check("bank[1]", 64'(bank[1]), 64'(32'h22));
        check("bank[2]", 64'(bank[2]), 64'(32'hDEADBEEF));
        check("bank[3]", 64'(bank[3]), 64'(0));

        // Reset during ISSUE of a write: command dropped, no response
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1;
        req_addr[0 +: AW] = 4'd3; req_wdata[0 +: DW] = 32'h55;
        acc = -1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (req_ready[0]) begin acc = cyc; break; end
            @(negedge clk);
        end
        check("reset-test accept", 64'(acc >= 0), 64'(1));
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("rf_wr forced low in rst", 64'(rf_wr), 64'(0));
        @(negedge clk);
        check_reset_outputs("mid-reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(0, 1'b0, 4'd3, '0, 32'h0, acc);
        drain();

        // Fill with 0xA0..0xA3, then back-to-back reads spaced 4 cycles
        for (int i = 0; i < 4; i++) issue(0, 1'b1, AW'(i), 32'hA0 + 32'(i), '0, acc);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b0, AW'(i), '0, 32'hA0 + 32'(i), acc);
            if (i > 0) check("read accept spacing", 64'(acc - prev), 64'(4));
            prev = acc;
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4-entry, 32-bit register bank (wr/addrin/datain/dataout, registered one-cycle read) among NREQ requesters.
- Accepts one command at a time over valid/ready.
- Drives the bank's write and read sequence, captures read data after the bank's read latency, and returns a one-hot response.
- Rejects out-of-range addresses without touching the bank.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 4, address width; matches the bank addrin.
- DW, 32, data width.
- NUM_REGS, 4, number of implemented bank registers; addresses >= NUM_REGS are illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-hot accept pulse
- req_wr  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*AW  requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  requester i at [i*DW +: DW]
- rsp_valid  out  NREQ  one-hot completion pulse to the granted requester
- rsp_err  out  1  qualified by rsp_valid; 1 = illegal address
- rsp_rdata  out  DW  qualified by rsp_valid; read data, 0 for writes and errors
- rf_wr  out  1  to bank wr
- rf_addr  out  AW  to bank addrin
- rf_wdata  out  DW  to bank datain
- rf_rdata  in  DW  from bank dataout

Behaviour:
- Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rf_wr=0, rf_addr=0, rf_wdata=0, rr pointer=NREQ-1 (requester 0 wins first).
- rf_wr is combinationally forced to 0 while rst=1.
- FSM states: IDLE, ISSUE, RDLAT, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid requester searching upward from (ptr+1) mod NREQ.
  - req_ready[g]=1 combinationally in this cycle; latch wr/addr/wdata/g.
  - Update ptr=g.
  - Next state is ISSUE if addr < NUM_REGS; otherwise RESP with the error flag set.
  - rf_wr=0 in IDLE.
- ISSUE (1 cycle):
  - rf_wr=cmd_wr, rf_addr=cmd_addr, rf_wdata=cmd_wdata.
  - Write: next state RESP.
  - Read: next state RDLAT.
- RDLAT (reads only):
  - rf_wr=0, rf_addr held.
  - rf_rdata is valid in this cycle; register it into rsp_rdata.
  - Next state RESP.
- RESP (1 cycle):
  - rsp_valid[g]=1; rsp_err=err flag; rsp_rdata = captured data for a good read, else 0.
  - Next state IDLE.
  - rsp_valid, rsp_err and rsp_rdata are registered outputs. rsp_rdata clears to 0 when rsp_valid drops.
- rf_addr and rf_wdata hold their last driven values outside ISSUE/RDLAT. rf_wr is 1 only in ISSUE for a legal write.
- Latency from accept cycle to rsp_valid: write = 2 cycles, read = 3 cycles, illegal = 1 cycle.
- Minimum spacing between accepts: write 3 cycles, read 4, illegal 2.
- Exactly one requester is ever granted or responded to at a time. The arbiter never accepts a new command before RESP.
- Requesters must hold valid and fields stable until ready. Requests arriving outside IDLE wait.
- Simultaneous valids: round-robin as above. A lone persistent requester is re-granted every IDLE visit.
- Write-then-read of the same address from different requesters: read returns the new data, because the write completes before the next accept.
- rst in any state: return to IDLE next edge, drop the in-flight command with no response, apply reset values.

Test Plan:
- Reset, then requester 0 writes addr 2 = 0xDEADBEEF: rf_wr=1 for exactly one cycle, rf_addr=2; rsp_valid=2'b01 two cycles after accept, rsp_err=0, rsp_rdata=0.
- Requester 1 reads addr 2 after the above: rsp_valid=2'b10 three cycles after accept, rsp_rdata=0xDEADBEEF; rf_wr stays 0 throughout.
- Both requesters hold valid with writes (r0: addr0=0x11, r1: addr1=0x22) for 4 grants: grant order 0,1,0,1; bank reads back 0x11 and 0x22.
- Requester 0 reads addr 7 (NUM_REGS=4): rsp_valid one cycle after accept, rsp_err=1, rsp_rdata=0, rf_wr never asserted; all 4 registers unchanged.
- Assert rst during ISSUE of a write of 0x55 to addr 3: no rsp_valid issued, all outputs return to reset values, and a subsequent read of addr 3 returns 0.
- Back-to-back reads by a single requester of addrs 0..3 after writing 0xA0..0xA3: responses 0xA0..0xA3 in order, accepts spaced exactly 4 cycles apart.
